// File: rtl/implication_monitor.sv
`default_nettype none
// ============================================================================
// Module   : implication_monitor
// Brief    : N-channel A->B checker, per-sample or bounded-response mode,
//            with violation pulse, sticky flags and saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module implication_monitor #(
    parameter int N       = 4,
    parameter int MAX_WIN = 7,
    parameter int WIN_W   = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic             mode,
    input  logic [WIN_W-1:0] window,
    input  logic             clear,
    output logic [N-1:0]     r,
    output logic [N-1:0]     viol,
    output logic [N-1:0]     sticky,
    output logic [N-1:0]     pending,
    output logic [CNT_W-1:0] viol_count
);

    localparam logic [0:0]       c_st_idle = 1'b0;
    localparam logic [0:0]       c_st_wait = 1'b1;
    localparam logic [WIN_W-1:0] c_max_win = WIN_W'(MAX_WIN);
    localparam int               c_sum_w   = CNT_W + 6;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [N-1:0]             r_state;
    logic [N-1:0][WIN_W-1:0]  r_timer;
    logic [N-1:0]             r_res;
    logic [N-1:0]             r_viol;
    logic [N-1:0]             r_sticky;
    logic [CNT_W-1:0]         r_count;

    logic [N-1:0]             w_state_nxt;
    logic [N-1:0][WIN_W-1:0]  w_timer_nxt;
    logic [N-1:0]             w_viol_nxt;
    logic [WIN_W-1:0]         w_win;
    logic [5:0]               w_pop;
    logic [c_sum_w-1:0]       w_sum;
    logic [CNT_W-1:0]         w_count_nxt;

    assign w_win = (window > c_max_win) ? c_max_win : window;

    // Channel FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_timer <= '0;
        end else if (clear) begin
            r_state <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Channel FSM next state; leaving mode 1 drops any WAIT silently
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        for (int i = 0; i < N; i++) begin
            if (!mode) begin
                w_state_nxt[i] = c_st_idle;
                w_timer_nxt[i] = '0;
            end else if (valid) begin
                if (r_state[i] == c_st_idle) begin
                    if (a[i] && !b[i] && (w_win != '0)) begin
                        w_state_nxt[i] = c_st_wait;
                        w_timer_nxt[i] = w_win;
                    end
                end else if (b[i] || (r_timer[i] == WIN_W'(1))) begin
                    w_state_nxt[i] = c_st_idle;
                    w_timer_nxt[i] = '0;
                end else begin
                    w_timer_nxt[i] = r_timer[i] - WIN_W'(1);
                end
            end
        end
    end

    // Violation decision per channel
    always_comb begin
        w_viol_nxt = '0;
        for (int i = 0; i < N; i++) begin
            if (valid) begin
                if (!mode) begin
                    w_viol_nxt[i] = a[i] & ~b[i];
                end else if (r_state[i] == c_st_idle) begin
                    w_viol_nxt[i] = a[i] & ~b[i] & (w_win == '0);
                end else begin
                    w_viol_nxt[i] = ~b[i] & (r_timer[i] == WIN_W'(1));
                end
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + 6'(w_viol_nxt[i]);
        end
        w_sum       = c_sum_w'(r_count) + c_sum_w'(w_pop);
        w_count_nxt = (w_sum > c_sum_w'(c_cnt_max)) ? c_cnt_max : w_sum[CNT_W-1:0];
    end

    // Result register ignores clear; violation bookkeeping does not
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res    <= '1;
            r_viol   <= '0;
            r_sticky <= '0;
            r_count  <= '0;
        end else begin
            if (valid) begin
                r_res <= ~a | b;
            end
            if (clear) begin
                r_viol   <= '0;
                r_sticky <= '0;
                r_count  <= '0;
            end else begin
                r_viol   <= w_viol_nxt;
                r_sticky <= r_sticky | w_viol_nxt;
                r_count  <= w_count_nxt;
            end
        end
    end

    assign r          = r_res;
    assign viol       = r_viol;
    assign sticky     = r_sticky;
    assign pending    = r_state;
    assign viol_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_implication_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_implication_monitor
// Brief    : Directed scoreboard bench for implication_monitor
//            (N=4, MAX_WIN=5, WIN_W=3, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_implication_monitor;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       mode;
    logic [2:0] window;
    logic       clear;
    logic [3:0] r;
    logic [3:0] viol;
    logic [3:0] sticky;
    logic [3:0] pending;
    logic [3:0] viol_count;

    typedef struct {
        int         id;
        logic [3:0] r;
        logic [3:0] viol;
        logic [3:0] sticky;
        logic [3:0] pend;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   step_id  = 0;

    implication_monitor #(
        .N(4), .MAX_WIN(5), .WIN_W(3), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .a(a), .b(b),
        .mode(mode), .window(window), .clear(clear),
        .r(r), .viol(viol), .sticky(sticky), .pending(pending),
        .viol_count(viol_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int id, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("r",          e.id, r,          e.r);
            check("viol",       e.id, viol,       e.viol);
            check("sticky",     e.id, sticky,     e.sticky);
            check("pending",    e.id, pending,    e.pend);
            check("viol_count", e.id, viol_count, e.cnt);
        end
    end

    task automatic step(input logic v, input logic [3:0] ia, input logic [3:0] ib,
                        input logic m, input logic [2:0] w, input logic c,
                        input logic [3:0] er, input logic [3:0] ev, input logic [3:0] es,
                        input logic [3:0] ep, input logic [3:0] ec);
        exp_t e;
        @(negedge clk);
        valid  = v;
        a      = ia;
        b      = ib;
        mode   = m;
        window = w;
        clear  = c;
        step_id++;
        e.id = step_id; e.r = er; e.viol = ev; e.sticky = es; e.pend = ep; e.cnt = ec;
        q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; a = '0; b = '0; mode = 1'b0; window = '0; clear = 1'b0;
        #12;
        check("rst_r",       0, r,          4'hF);
        check("rst_viol",    0, viol,       4'h0);
        check("rst_sticky",  0, sticky,     4'h0);
        check("rst_pending", 0, pending,    4'h0);
        check("rst_count",   0, viol_count, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode 0 truth table on channel 0
        step(1, 4'h0, 4'h0, 0, 0, 0,  4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        step(1, 4'h0, 4'h1, 0, 0, 0,  4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        step(1, 4'h1, 4'h0, 0, 0, 0,  4'hE, 4'h1, 4'h1, 4'h0, 4'h1);
        step(1, 4'h1, 4'h1, 0, 0, 0,  4'hF, 4'h0, 4'h1, 4'h0, 4'h1);
        step(0, 4'h0, 4'h0, 0, 0, 1,  4'hF, 4'h0, 4'h0, 4'h0, 4'h0);

        // Mode 1, window 3, satisfied after two samples
        step(1, 4'h1, 4'h0, 1, 3, 0,  4'hE, 4'h0, 4'h0, 4'h1, 4'h0);
        step(1, 4'h0, 4'h0, 1, 3, 0,  4'hF, 4'h0, 4'h0, 4'h1, 4'h0);
        step(1, 4'h0, 4'h1, 1, 3, 0,  4'hF, 4'h0, 4'h0, 4'h0, 4'h0);

        // Mode 1, window 3, gated valid, repeated A ignored, deadline miss
        step(1, 4'h1, 4'h0, 1, 3, 0,  4'hE, 4'h0, 4'h0, 4'h1, 4'h0);
        step(1, 4'h1, 4'h0, 1, 3, 0,  4'hE, 4'h0, 4'h0, 4'h1, 4'h0);
        step(0, 4'h0, 4'h0, 1, 3, 0,  4'hE, 4'h0, 4'h0, 4'h1, 4'h0);
        step(1, 4'h0, 4'h0, 1, 3, 0,  4'hF, 4'h0, 4'h0, 4'h1, 4'h0);
        step(0, 4'h0, 4'h0, 1, 3, 0,  4'hF, 4'h0, 4'h0, 4'h1, 4'h0);
        step(1, 4'h0, 4'h0, 1, 3, 0,  4'hF, 4'h1, 4'h1, 4'h0, 4'h1);
        step(0, 4'h0, 4'h0, 1, 3, 0,  4'hF, 4'h0, 4'h1, 4'h0, 4'h1);

        // Window 7 clamps to 5 on channel 1
        step(1, 4'h2, 4'h0, 1, 7, 0,  4'hD, 4'h0, 4'h1, 4'h2, 4'h1);
        for (int k = 0; k < 4; k++)
            step(1, 4'h0, 4'h0, 1, 7, 0,  4'hF, 4'h0, 4'h1, 4'h2, 4'h1);
        step(1, 4'h0, 4'h0, 1, 7, 0,  4'hF, 4'h2, 4'h3, 4'h0, 4'h2);

        // Window 0 in mode 1 behaves as same-sample check on channel 2
        step(1, 4'h4, 4'h0, 1, 0, 0,  4'hB, 4'h4, 4'h7, 4'h0, 4'h3);

        // Switching to mode 0 abandons WAIT without violation
        step(1, 4'h1, 4'h0, 1, 3, 0,  4'hE, 4'h0, 4'h7, 4'h1, 4'h3);
        step(1, 4'h0, 4'h0, 0, 3, 0,  4'hF, 4'h0, 4'h7, 4'h0, 4'h3);
        step(1, 4'h0, 4'h0, 1, 3, 0,  4'hF, 4'h0, 4'h7, 4'h0, 4'h3);

        // Clear on the deciding sample discards the violation
        step(1, 4'h1, 4'h0, 1, 1, 0,  4'hE, 4'h0, 4'h7, 4'h1, 4'h3);
        step(1, 4'h0, 4'h0, 1, 1, 1,  4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        step(1, 4'h0, 4'h0, 1, 1, 0,  4'hF, 4'h0, 4'h0, 4'h0, 4'h0);

        // Counter saturation: 4 violations per sample, 5 samples
        for (int k = 0; k < 5; k++)
            step(1, 4'hF, 4'h0, 0, 0, 0,  4'h0, 4'hF, 4'hF, 4'h0,
                 (k < 3) ? 4'(4 * (k + 1)) : 4'hF);
        step(0, 4'h0, 4'h0, 0, 0, 1,  4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Asynchronous reset in the middle of WAIT
        step(1, 4'h1, 4'h0, 1, 3, 0,  4'hE, 4'h0, 4'h0, 4'h1, 4'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_r",       step_id, r,          4'hF);
        check("arst_viol",    step_id, viol,       4'h0);
        check("arst_sticky",  step_id, sticky,     4'h0);
        check("arst_pending", step_id, pending,    4'h0);
        check("arst_count",   step_id, viol_count, 4'h0);
        @(negedge clk);
        valid = 1'b0; a = '0; b = '0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            step(1, 4'h0, 4'h0, 1, 3, 0,  4'hF, 4'h0, 4'h0, 4'h0, 4'h0);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
